// File: rtl/multi_digit_bcd_counter.sv
// multi_digit_bcd_counter: debounced push-button driven N-digit BCD up/down counter
// with wrap carry pulse and a multiplexed seven-segment display driver.
module multi_digit_bcd_counter #(
   parameter int N_DIGITS        = 4,
   parameter int DEBOUNCE_CYCLES = 1000000,
   parameter int SCAN_CYCLES     = 50000
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  btn,
   input  logic                  up_dn,
   input  logic                  en,
   output logic [4*N_DIGITS-1:0] bcd,
   output logic                  carry,
   output logic [6:0]            seg,
   output logic [N_DIGITS-1:0]   an
);
   localparam int DW = $clog2(DEBOUNCE_CYCLES);
   localparam int SW = $clog2(SCAN_CYCLES);
   localparam int IW = N_DIGITS > 1 ? $clog2(N_DIGITS) : 1;

   logic [1:0]            sync_q;
   logic                  filt_q, filt_d, filt_prev_q;
   logic [DW-1:0]         db_cnt_q, db_cnt_d;
   logic                  db_hit, req;
   logic [4*N_DIGITS-1:0] bcd_q, bcd_d;
   logic                  carry_q, wrap, c;
   logic [3:0]            dig, cur;
   logic [SW-1:0]         scan_q, scan_d;
   logic                  scan_wrap;
   logic [IW-1:0]         idx_q, idx_d;

   always_comb begin
      db_hit   = sync_q[1] != filt_q && db_cnt_q == DW'(DEBOUNCE_CYCLES - 1);
      filt_d   = db_hit ? sync_q[1] : filt_q;
      db_cnt_d = (sync_q[1] == filt_q || db_hit) ? '0 : db_cnt_q + 1'b1;
      req      = filt_q & ~filt_prev_q & en;
   end

   // Ripple carry/borrow through the digits; c left set after the last digit means wrap.
   always_comb begin
      c     = 1'b1;
      dig   = '0;
      bcd_d = bcd_q;
      for (int i = 0; i < N_DIGITS; i++) begin
         dig = bcd_q[4*i +: 4];
         if (c) begin
            bcd_d[4*i +: 4] = up_dn ? (dig >= 4'd9 ? 4'd0 : dig + 4'd1)
                                    : ((dig == 4'd0 || dig > 4'd9) ? 4'd9 : dig - 4'd1);
            c = up_dn ? dig >= 4'd9 : dig == 4'd0;
         end
      end
      wrap = c;
   end

   always_comb begin
      scan_wrap = scan_q == SW'(SCAN_CYCLES - 1);
      scan_d    = scan_wrap ? '0 : scan_q + 1'b1;
      idx_d     = scan_wrap ? (idx_q == IW'(N_DIGITS - 1) ? '0 : idx_q + 1'b1) : idx_q;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sync_q      <= '0;
         filt_q      <= 1'b0;
         filt_prev_q <= 1'b0;
         db_cnt_q    <= '0;
         bcd_q       <= '0;
         carry_q     <= 1'b0;
         scan_q      <= '0;
         idx_q       <= '0;
      end else begin
         sync_q      <= {sync_q[0], btn};
         filt_q      <= filt_d;
         filt_prev_q <= filt_q;
         db_cnt_q    <= db_cnt_d;
         if (req) bcd_q <= bcd_d;
         carry_q     <= req & wrap;
         scan_q      <= scan_d;
         idx_q       <= idx_d;
      end
   end

   always_comb begin
      cur = '0;
      an  = '0;
      for (int i = 0; i < N_DIGITS; i++) begin
         an[i] = idx_q == IW'(i);
         if (idx_q == IW'(i)) cur = bcd_q[4*i +: 4];
      end
   end

   always_comb begin
      case (cur)
         4'd0:    seg = 7'b0111111;
         4'd1:    seg = 7'b0000110;
         4'd2:    seg = 7'b1011011;
         4'd3:    seg = 7'b1001111;
         4'd4:    seg = 7'b1100110;
         4'd5:    seg = 7'b1101101;
         4'd6:    seg = 7'b1111101;
         4'd7:    seg = 7'b0000111;
         4'd8:    seg = 7'b1111111;
         4'd9:    seg = 7'b1101111;
         default: seg = 7'b0000000;
      endcase
   end

   assign bcd   = bcd_q;
   assign carry = carry_q;
endmodule

// File: tb/tb_multi_digit_bcd_counter.sv
// tb_multi_digit_bcd_counter: directed checks of counting, wrap carry, debounce
// latency, enable gating, display scanning and asynchronous reset.
module tb_multi_digit_bcd_counter;
   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        btn = 1'b0;
   logic        up_dn = 1'b1;
   logic        en = 1'b1;
   logic [15:0] bcd;
   logic        carry;
   logic [6:0]  seg;
   logic [3:0]  an;
   int          total = 0;
   int          passed = 0;

   multi_digit_bcd_counter #(.N_DIGITS(4), .DEBOUNCE_CYCLES(4), .SCAN_CYCLES(3)) dut (
      .clk(clk), .rst(rst), .btn(btn), .up_dn(up_dn), .en(en),
      .bcd(bcd), .carry(carry), .seg(seg), .an(an)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
   endtask

   task automatic press(input logic dir);
      @(negedge clk);
      up_dn = dir;
      btn = 1'b1;
      repeat (6) @(posedge clk);
      @(negedge clk);
      btn = 1'b0;
      repeat (8) @(posedge clk);
   endtask

   // Edge-accurate press: btn first sampled on edge 0, bcd must move on edge 6.
   task automatic press_exact(input logic dir, input logic [15:0] old_v,
                              input logic [15:0] new_v, input logic exp_carry, input string tag);
      @(negedge clk);
      up_dn = dir;
      btn = 1'b1;
      @(posedge clk);
      repeat (5) @(posedge clk);
      #1;
      check({tag, "_pre_bcd"}, 32'(bcd), 32'(old_v));
      check({tag, "_pre_carry"}, 32'(carry), 0);
      @(posedge clk);
      #1;
      check({tag, "_e6_bcd"}, 32'(bcd), 32'(new_v));
      check({tag, "_e6_carry"}, 32'(carry), 32'(exp_carry));
      @(posedge clk);
      #1;
      check({tag, "_e7_bcd"}, 32'(bcd), 32'(new_v));
      check({tag, "_e7_carry"}, 32'(carry), 0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      btn = 1'b0;
      repeat (10) @(posedge clk);
   endtask

   initial begin
      logic [6:0] seg_exp [4] = '{7'b1100110, 7'b1001111, 7'b1011011, 7'b0000110};
      logic [3:0] an_exp [4]  = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
      logic [3:0] prev;
      bit found;
      #1;
      check("rst_bcd", 32'(bcd), 0);
      check("rst_carry", 32'(carry), 0);
      check("rst_an", 32'(an), 32'h1);
      check("rst_seg", 32'(seg), 32'h3f);
      repeat (3) @(negedge clk);
      rst = 1'b1;

      repeat (9) press(1'b1);
      check("up9", 32'(bcd), 32'h0009);
      press_exact(1'b1, 16'h0009, 16'h0010, 1'b0, "up10");

      @(negedge clk) rst = 1'b0;
      @(negedge clk) rst = 1'b1;
      press_exact(1'b0, 16'h0000, 16'h9999, 1'b1, "dnwrap");
      press_exact(1'b1, 16'h9999, 16'h0000, 1'b1, "upwrap");
      press(1'b0);
      check("dn_9999", 32'(bcd), 32'h9999);
      press(1'b0);
      check("dn_9998", 32'(bcd), 32'h9998);

      @(negedge clk) rst = 1'b0;
      @(negedge clk) rst = 1'b1;
      @(negedge clk);
      up_dn = 1'b1;
      btn = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      btn = 1'b0;
      repeat (10) @(posedge clk);
      #1;
      check("short_pulse", 32'(bcd), 0);
      press_exact(1'b1, 16'h0000, 16'h0001, 1'b0, "latency");
      en = 1'b0;
      press(1'b1);
      en = 1'b1;
      #1;
      check("en_off", 32'(bcd), 32'h0001);

      repeat (1233) press(1'b1);
      check("reach_1234", 32'(bcd), 32'h1234);

      found = 1'b0;
      for (int k = 0; k < 20 && !found; k++) begin
         prev = an;
         @(negedge clk);
         found = prev == 4'b1000 && an == 4'b0001;
      end
      check("scan_sync", 32'(found), 1);
      for (int j = 0; j < 12; j++) begin
         if (j > 0) @(negedge clk);
         check($sformatf("scan_an_%0d", j), 32'(an), 32'(an_exp[j/3]));
         check($sformatf("scan_seg_%0d", j), 32'(seg), 32'(seg_exp[j/3]));
      end

      @(negedge clk);
      btn = 1'b1;
      repeat (3) @(posedge clk);
      #2 rst = 1'b0;
      #1;
      check("async_bcd", 32'(bcd), 0);
      check("async_carry", 32'(carry), 0);
      check("async_an", 32'(an), 32'h1);
      check("async_seg", 32'(seg), 32'h3f);
      btn = 1'b0;
      @(negedge clk) rst = 1'b1;
      repeat (12) @(posedge clk);
      #1;
      check("no_count_after_rst", 32'(bcd), 0);

      @(negedge clk);
      rst = 1'b0;
      btn = 1'b1;
      @(negedge clk) rst = 1'b1;
      repeat (20) @(posedge clk);
      #1;
      check("held_across_rst", 32'(bcd), 32'h0001);
      @(negedge clk) btn = 1'b0;
      repeat (10) @(posedge clk);
      #1;
      check("held_single", 32'(bcd), 32'h0001);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule

// File: doc/multi_digit_bcd_counter.md
MULTI_DIGIT_BCD_COUNTER -- requirements
Module: multi_digit_bcd_counter

Interface
REQ-001 SHALL have parameter N_DIGITS, default 4, giving the number of cascaded BCD digits (legal 1..8).
REQ-002 SHALL have parameter DEBOUNCE_CYCLES, default 1000000, giving the consecutive stable clk cycles needed to accept a push-button level change (legal >= 2).
REQ-003 SHALL have parameter SCAN_CYCLES, default 50000, giving the clk cycles each digit is shown during display multiplexing (legal >= 2).
REQ-004 SHALL have port clk, input, 1 bit: the single system clock; all state is updated on its rising edge.
REQ-005 SHALL have port rst, input, 1 bit: asynchronous, active-low reset.
REQ-006 SHALL have port btn, input, 1 bit: raw, asynchronous and bouncing push-button, active-high.
REQ-007 SHALL have port up_dn, input, 1 bit: count direction, 1 = up and 0 = down.
REQ-008 SHALL have port en, input, 1 bit: count enable, 1 = accept presses.
REQ-009 SHALL have port bcd, output, 4*N_DIGITS bits: the count value, with digit i at bits [4i+3:4i] and digit 0 as the least significant.
REQ-010 SHALL have port carry, output, 1 bit: a one-cycle pulse on wrap-around in either direction.
REQ-011 SHALL have port seg, output, 7 bits: segments, active-high, with seg[0] = A through seg[6] = G.
REQ-012 SHALL have port an, output, N_DIGITS bits: one-hot, active-high digit select, with an[i] selecting digit i.

Function
REQ-013 SHALL pass btn through a two-flip-flop synchroniser before any other use.
REQ-014 SHALL debounce the synchronised level as follows:
- A stability counter increments on every cycle in which the synchronised level differs from the filtered level.
- The stability counter clears to 0 on any cycle in which the two levels are equal.
- When the counter equals DEBOUNCE_CYCLES-1 and the levels still differ, the filtered level takes the synchronised value and the counter clears.
REQ-015 SHALL generate one count request per rising edge of the filtered level, and none on its falling edge.
REQ-016 SHALL apply the following latency: with the first clk edge that samples btn=1 numbered edge 0, and btn held high, bcd SHALL change on edge DEBOUNCE_CYCLES+2.
REQ-017 SHALL ignore any btn pulse shorter than DEBOUNCE_CYCLES cycles after synchronisation, producing no count.
REQ-018 SHALL discard a count request when en=0 on that cycle; debounce and display scan continue regardless of en.
REQ-019 SHALL sample up_dn on the same cycle as the count request.
REQ-020 SHALL count up as follows:
- Digit 0 increments.
- A digit at 9 becomes 0 and carries into the next digit.
- All digits at 9 become all 0, and carry=1 for exactly one cycle.
REQ-021 SHALL count down as follows:
- Digit 0 decrements.
- A digit at 0 becomes 9 and borrows from the next digit.
- All digits at 0 become all 9, and carry=1 for exactly one cycle.
REQ-022 SHALL hold every digit within 0..9 at all times; no digit value of 10..15 is ever reachable.
REQ-023 SHALL multiplex the display as follows:
- A scan counter counts 0..SCAN_CYCLES-1 and wraps.
- The digit index advances (N_DIGITS-1 wraps to 0) on the cycle the scan counter wraps.
- Each digit is therefore displayed for exactly SCAN_CYCLES cycles.
REQ-024 SHALL drive an as one-hot at the current digit index, and seg as the decode of that digit's current bcd value.
REQ-025 SHALL decode seg (G..A) as: 0=0111111, 1=0000110, 2=1011011, 3=1001111, 4=1100110, 5=1101101, 6=1111101, 7=0000111, 8=1111111, 9=1101111, and any other value = 0000000.
REQ-026 SHALL reflect a bcd change on seg in the same cycle whenever the changed digit is the one currently selected.

Reset
REQ-027 SHALL, while rst=0, immediately force:
- bcd=0 and carry=0
- filtered level, stability counter, synchroniser, scan counter and digit index all at 0
- an=1 (digit 0) and seg=0111111
REQ-028 SHALL abandon any in-progress debounce or scan on reset, with no count occurring.
REQ-029 SHALL, if btn is held high across reset release, register exactly one count after the debounce time.

Verification (N_DIGITS=4, DEBOUNCE_CYCLES=4, SCAN_CYCLES=3, en=1)
REQ-030 SHALL verify up counting: after reset, 9 clean up presses -> bcd=16'h0009; a 10th press -> bcd=16'h0010 with carry=0.
REQ-031 SHALL verify up wrap: from bcd=16'h9999, one up press -> bcd=16'h0000, with carry high for exactly one cycle on the update edge.
REQ-032 SHALL verify down wrap: from bcd=16'h0000 with up_dn=0, one press -> bcd=16'h9999 with a one-cycle carry; a second press -> bcd=16'h9998.
REQ-033 SHALL verify debounce and latency: btn high for 3 cycles -> no change; btn high for 10 cycles -> exactly one increment, at edge 6; a press with en=0 -> no change.
REQ-034 SHALL verify scanning: with bcd=16'h1234, an steps 0001,0010,0100,1000 and repeats, 3 cycles each, while seg shows 1100110, 1001111, 1011011, 0000110 in step.
REQ-035 SHALL verify reset mid-operation: rst=0 asserted mid-debounce and mid-scan -> outputs reach reset values without waiting for clk, and no count follows release unless btn is still high.
